wb_stage: RTL and testbench



---
 rtl/wb_stage_if.sv | 28 ++
 rtl/wb_stage.sv | 91 +++++++++
 tb/tb_wb_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Bus bundle between the memory stage, decode read ports and the write-back stage.
// The wb_stage sits on the slave side; the upstream/decode logic drives the master side.
interface wb_stage_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic [1:0]            wb;
  logic [DATA_W-1:0]     read_data;
  logic [DATA_W-1:0]     address_WB;
  logic [REG_ADDR_W-1:0] reg_WB;
  logic [REG_ADDR_W-1:0] rs_addr;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0]     rs_data;
  logic [DATA_W-1:0]     rt_data;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0]     wb_data;

  modport master (
    output wb, read_data, address_WB, reg_WB, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_reg_write, wb_dest, wb_data
  );

  modport slave (
    input  wb, read_data, address_WB, reg_WB, rs_addr, rt_addr,
    output rs_data, rt_data, wb_reg_write, wb_dest, wb_data
  );
endinterface

// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB pipeline register, write-back select and the
// 32x32 register file with write-first bypassed combinational read ports.
module wb_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       flush,
  wb_stage_if.slave  bus
);

  logic [1:0]            r_wb_q;
  logic [DATA_W-1:0]     r_mem_q;
  logic [DATA_W-1:0]     r_alu_q;
  logic [REG_ADDR_W-1:0] r_dest_q;

  logic                  w_we;
  logic [DATA_W-1:0]     w_wb_data;
  logic [DATA_W-1:0]     w_rs_data;
  logic [DATA_W-1:0]     w_rt_data;

  logic [DATA_W-1:0]     r_regs [NUM_REGS];

  // A flush only needs to kill the control bits; data fields are don't-care.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_q   <= '0;
      r_mem_q  <= '0;
      r_alu_q  <= '0;
      r_dest_q <= '0;
    end else if (flush) begin
      r_wb_q   <= '0;
    end else if (!stall) begin
      r_wb_q   <= bus.wb;
      r_mem_q  <= bus.read_data;
      r_alu_q  <= bus.address_WB;
      r_dest_q <= bus.reg_WB;
    end
  end

  always_comb begin
    w_wb_data = r_wb_q[0] ? r_mem_q : r_alu_q;
    w_we      = r_wb_q[1] && (r_dest_q != '0);
  end

  // Entry 0 is a constant zero; every other entry has its own write decode.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (g == 0) begin : g_zero
      always_ff @(posedge clk) begin
        r_regs[g] <= '0;
      end
    end else begin : g_live
      localparam logic [REG_ADDR_W-1:0] IDX = REG_ADDR_W'(g);
      always_ff @(posedge clk) begin
        if (reset) begin
          r_regs[g] <= '0;
        end else if (w_we && (r_dest_q == IDX)) begin
          r_regs[g] <= w_wb_data;
        end
      end
    end
  end

  always_comb begin
    w_rs_data = r_regs[bus.rs_addr];
    if (bus.rs_addr == '0) begin
      w_rs_data = '0;
    end else if (w_we && (bus.rs_addr == r_dest_q)) begin
      w_rs_data = w_wb_data;
    end
  end

  always_comb begin
    w_rt_data = r_regs[bus.rt_addr];
    if (bus.rt_addr == '0) begin
      w_rt_data = '0;
    end else if (w_we && (bus.rt_addr == r_dest_q)) begin
      w_rt_data = w_wb_data;
    end
  end

  assign bus.rs_data      = w_rs_data;
  assign bus.rt_data      = w_rt_data;
  assign bus.wb_reg_write = w_we;
  assign bus.wb_dest      = r_dest_q;
  assign bus.wb_data      = w_wb_data;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_wb_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic reset, stall, flush;

  wb_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

  wb_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .NUM_REGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: architectural register array plus the instruction
  // currently sitting in write-back.
  logic [31:0] m_regs [32];
  logic        m_has_wr;
  logic        m_is_load;
  logic [31:0] m_load_val, m_alu_val;
  logic [4:0]  m_dest;
  bit          m_bubble;
  bit          m_init = 0;

  function automatic logic [31:0] m_value();
    return m_is_load ? m_load_val : m_alu_val;
  endfunction

  function automatic logic m_we();
    return m_has_wr && (m_dest != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_we() && a == m_dest) return m_value();
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_has_wr = 0; m_is_load = 0; m_load_val = 0; m_alu_val = 0; m_dest = 0;
      m_bubble = 0;
      m_init = 1;
    end else if (m_init) begin
      if (m_we()) m_regs[m_dest] = m_value();
      if (flush) begin
        m_has_wr = 0; m_is_load = 0;
        m_bubble = 1;
      end else if (!stall) begin
        m_has_wr   = bus.wb[1];
        m_is_load  = bus.wb[0];
        m_load_val = bus.read_data;
        m_alu_val  = bus.address_WB;
        m_dest     = bus.reg_WB;
        m_bubble   = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_init && !reset) begin
      chk("model.we", {31'd0, bus.wb_reg_write}, {31'd0, m_we()});
      chk("model.rs", bus.rs_data, m_read(bus.rs_addr));
      chk("model.rt", bus.rt_data, m_read(bus.rt_addr));
      if (!m_bubble) begin
        chk("model.dest", {27'd0, bus.wb_dest}, {27'd0, m_dest});
        chk("model.data", bus.wb_data, m_value());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] w, input logic [31:0] rd, input logic [31:0] ad,
                       input logic [4:0] r);
    bus.wb = w; bus.read_data = rd; bus.address_WB = ad; bus.reg_WB = r;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    drive(2'b00, 32'd0, 32'd0, 5'd0);
    bus.rs_addr = 5'd0; bus.rt_addr = 5'd0;
    step(); step();

    // Reset state
    reset = 0; bus.rs_addr = 5'd5; bus.rt_addr = 5'd31;
    @(negedge clk);
    chk("rst.rs", bus.rs_data, 32'd0);
    chk("rst.rt", bus.rt_data, 32'd0);
    chk("rst.we", {31'd0, bus.wb_reg_write}, 32'd0);

    // ALU write to $8
    drive(2'b10, 32'd0, 32'h0000_00AA, 5'd8);
    step();
    drive(2'b00, 32'd0, 32'd0, 5'd8);
    @(negedge clk);
    chk("alu.data", bus.wb_data, 32'hAA);
    chk("alu.we", {31'd0, bus.wb_reg_write}, 32'd1);
    chk("alu.dest", {27'd0, bus.wb_dest}, 32'd8);
    step();
    bus.rs_addr = 5'd8;
    @(negedge clk);
    chk("alu.readback", bus.rs_data, 32'hAA);

    // Load write with bypass before the regfile update
    drive(2'b11, 32'hDEAD_BEEF, 32'h10, 5'd9);
    step();
    drive(2'b00, 32'd0, 32'd0, 5'd1);
    bus.rs_addr = 5'd9;
    @(negedge clk);
    chk("load.bypass", bus.rs_data, 32'hDEAD_BEEF);
    chk("load.data", bus.wb_data, 32'hDEAD_BEEF);
    step();

    // $0 protection
    drive(2'b10, 32'd0, 32'h1234, 5'd0);
    step();
    drive(2'b00, 32'd0, 32'd0, 5'd1);
    bus.rs_addr = 5'd0;
    @(negedge clk);
    chk("zero.we", {31'd0, bus.wb_reg_write}, 32'd0);
    chk("zero.rs_wb", bus.rs_data, 32'd0);
    step();
    @(negedge clk);
    chk("zero.rs_after", bus.rs_data, 32'd0);

    // Stall holds the captured write; new inputs are ignored
    drive(2'b10, 32'd0, 32'h5, 5'd3);
    step();
    stall = 1;
    drive(2'b10, 32'd0, 32'h9, 5'd4);
    bus.rt_addr = 5'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall.dest", {27'd0, bus.wb_dest}, 32'd3);
      chk("stall.r4", bus.rt_data, 32'd0);
      step();
    end
    flush = 1;
    step();
    @(negedge clk);
    chk("flush.we", {31'd0, bus.wb_reg_write}, 32'd0);
    stall = 0; flush = 0;
    drive(2'b00, 32'd0, 32'd0, 5'd1);
    bus.rs_addr = 5'd3;
    step();
    @(negedge clk);
    chk("stall.r3", bus.rs_data, 32'h5);
    chk("stall.r4_after", bus.rt_data, 32'd0);

    // Reset while a write is pending
    drive(2'b10, 32'd0, 32'h77, 5'd12);
    step();
    reset = 1;
    drive(2'b00, 32'd0, 32'd0, 5'd0);
    step();
    reset = 0;
    bus.rs_addr = 5'd12; bus.rt_addr = 5'd3;
    @(negedge clk);
    chk("rstw.r12", bus.rs_data, 32'd0);
    chk("rstw.r3", bus.rt_data, 32'd0);
    chk("rstw.we", {31'd0, bus.wb_reg_write}, 32'd0);
    chk("rstw.dest", {27'd0, bus.wb_dest}, 32'd0);
    chk("rstw.data", bus.wb_data, 32'd0);

    // Randomized traffic; small index pool keeps bypass hits frequent
    for (int c = 0; c < 3000; c++) begin
      step();
      reset = ($urandom_range(0, 199) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      bus.wb         = 2'($urandom_range(0, 3));
      bus.read_data  = $urandom;
      bus.address_WB = $urandom;
      bus.reg_WB     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                   : 5'($urandom_range(0, 5));
      bus.rs_addr    = 5'($urandom_range(0, 6));
      bus.rt_addr    = ($urandom_range(0, 3) == 0) ? bus.rs_addr
                                                   : 5'($urandom_range(0, 31));
    end
    step();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
